// File: rtl/reg_write_sequencer.sv
// Register write-bus initiator: FIFO-buffered command bytes replayed as spaced strobes.
// Define REG_WRITE_SEQ_WAIT_CMD_EN to treat address 7 as a timed wait (data x TICK cycles).
module reg_write_sequencer #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2,
    parameter int TICK  = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    output logic       write_strobe,
    output logic [2:0] address,
    output logic [4:0] data,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_GAP
`ifdef REG_WRITE_SEQ_WAIT_CMD_EN
        , S_WAIT
`endif
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, push, pop;
    logic [7:0]    head;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          strobe_q, strobe_d;
    logic [2:0]    addr_q, addr_d;
    logic [4:0]    data_q, data_d;
    logic          dispatch;
    logic          head_is_wait;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= cmd_byte;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef REG_WRITE_SEQ_WAIT_CMD_EN
    // Sized to hold 31*TICK-1; a zero-length wait still occupies one cycle.
    localparam int WW = $clog2(31 * TICK + 1);
    logic [WW-1:0] wait_cnt_q, wait_cnt_d, wait_load;

    assign head_is_wait = (head[7:5] == 3'd7);
    assign wait_load    = (head[4:0] == 5'd0) ? '0
                        : WW'(head[4:0]) * WW'(TICK) - WW'(1);

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end
`else
    assign head_is_wait = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= '0;
            strobe_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            strobe_q  <= strobe_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        strobe_d  = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        pop       = 1'b0;
        dispatch  = 1'b0;
`ifdef REG_WRITE_SEQ_WAIT_CMD_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE:   dispatch = 1'b1;
            S_STROBE: begin
                state_d   = S_GAP;
                gap_cnt_d = GW'(GAP - 1);
            end
            S_GAP: begin
                if (gap_cnt_q == '0) dispatch = 1'b1;
                else                 gap_cnt_d = gap_cnt_q - GW'(1);
            end
`ifdef REG_WRITE_SEQ_WAIT_CMD_EN
            S_WAIT: begin
                if (wait_cnt_q == '0) dispatch = 1'b1;
                else                  wait_cnt_d = wait_cnt_q - WW'(1);
            end
`endif
            default:  state_d = S_IDLE;
        endcase

        // Shared by IDLE and the final GAP/WAIT cycle so back-to-back commands lose no cycle.
        if (dispatch) begin
            if (!empty) begin
                pop = 1'b1;
                if (head_is_wait) begin
`ifdef REG_WRITE_SEQ_WAIT_CMD_EN
                    state_d    = S_WAIT;
                    wait_cnt_d = wait_load;
`endif
                end else begin
                    state_d  = S_STROBE;
                    strobe_d = 1'b1;
                    addr_d   = head[7:5];
                    data_d   = head[4:0];
                end
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    assign write_strobe = strobe_q;
    assign address      = addr_q;
    assign data         = data_q;
    assign busy         = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed bench for reg_write_sequencer (DEPTH=4, GAP=2, TICK=4); follows REG_WRITE_SEQ_WAIT_CMD_EN.
module tb_reg_write_sequencer;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int TICK  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       write_strobe;
    logic [2:0] address;
    logic [4:0] data;
    logic       busy;

    reg_write_sequencer #(.DEPTH(DEPTH), .GAP(GAP), .TICK(TICK)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_byte(cmd_byte), .write_strobe(write_strobe), .address(address),
        .data(data), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log, sampled mid-cycle.
    int         s_cyc [$];
    logic [2:0] s_addr[$];
    logic [4:0] s_data[$];
    int         a7_cnt = 0;
    always @(negedge clk) begin
        if (write_strobe === 1'b1) begin
            s_cyc.push_back(cyc);
            s_addr.push_back(address);
            s_data.push_back(data);
            if (address == 3'd7) a7_cnt++;
        end
    end

    int vectors    = 0;
    int miscompares = 0;
    int rdy_low    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        logic ok;
        logic done;
        done      = 1'b0;
        cmd_valid = 1'b1;
        cmd_byte  = b;
        for (int i = 0; i < 100 && !done; i++) begin
            ok = cmd_ready;
            if (!ok) rdy_low++;
            tick();
            if (ok) done = 1'b1;
        end
        if (!done) chk("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && busy !== 1'b0; i++) tick();
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic chk_strobe(input string tag, input int idx, input logic [2:0] a, input logic [4:0] d);
        chk({tag, "_addr"}, 32'(s_addr[idx]), 32'(a));
        chk({tag, "_data"}, 32'(s_data[idx]), 32'(d));
    endtask

    logic [2:0] burst_a [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
    logic [4:0] burst_d [8] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
    logic [7:0] burst_b [8] = '{8'h21, 8'h42, 8'h63, 8'h84, 8'hA5, 8'hC6, 8'h07, 8'h28};

    initial begin
        int base;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        tick();
        tick();
        chk("rst_strobe", 32'(write_strobe), 32'd0);
        chk("rst_addr",   32'(address),      32'd0);
        chk("rst_data",   32'(data),         32'd0);
        chk("rst_busy",   32'(busy),         32'd0);
        chk("rst_ready",  32'(cmd_ready),    32'd1);
        rst = 1'b0;
        tick();

        // Single write 0x0A: strobe the cycle after acceptance, busy clears after GAP.
        base      = s_cyc.size();
        cmd_valid = 1'b1;
        cmd_byte  = 8'h0A;
        tick();
        cmd_valid = 1'b0;
        chk("single_busy_up",  32'(busy),         32'd1);
        chk("single_no_early", 32'(write_strobe), 32'd0);
        tick();
        chk("single_strobe",   32'(write_strobe), 32'd1);
        chk("single_addr",     32'(address),      32'd0);
        chk("single_data",     32'(data),         32'd10);
        tick();
        chk("single_width",    32'(write_strobe), 32'd0);
        tick();
        chk("single_busy_gap", 32'(busy),         32'd1);
        tick();
        chk("single_busy_end", 32'(busy),         32'd0);
        chk("single_count",    32'(s_cyc.size() - base), 32'd1);
        chk("single_hold_d",   32'(data),         32'd10);

        // Burst of 8 with valid held: FIFO fills, ready drops, strobes every GAP+1.
        base    = s_cyc.size();
        rdy_low = 0;
        for (int k = 0; k < 8; k++) send(burst_b[k]);
        cmd_valid = 1'b0;
        wait_idle(200);
        chk("burst_ready_low", 32'(rdy_low > 0), 32'd1);
        chk("burst_count", 32'(s_cyc.size() - base), 32'd8);
        if (s_cyc.size() == base + 8) begin
            for (int k = 0; k < 8; k++) begin
                chk_strobe($sformatf("burst%0d", k), base + k, burst_a[k], burst_d[k]);
                if (k > 0)
                    chk($sformatf("burst%0d_space", k), 32'(s_cyc[base+k] - s_cyc[base+k-1]), 32'd3);
            end
        end

`ifdef REG_WRITE_SEQ_WAIT_CMD_EN
        // Write, wait 3 ticks (12 cycles), write: spacing 1+GAP+12.
        base = s_cyc.size();
        send(8'h05);
        send(8'hE3);
        send(8'h06);
        cmd_valid = 1'b0;
        wait_idle(200);
        chk("wait3_count", 32'(s_cyc.size() - base), 32'd2);
        if (s_cyc.size() == base + 2) begin
            chk_strobe("wait3_first",  base,     3'd0, 5'd5);
            chk_strobe("wait3_second", base + 1, 3'd0, 5'd6);
            chk("wait3_space", 32'(s_cyc[base+1] - s_cyc[base]), 32'd15);
        end

        // Zero-length wait still takes one cycle: spacing 1+GAP+1.
        base = s_cyc.size();
        send(8'h01);
        send(8'hE0);
        send(8'h02);
        cmd_valid = 1'b0;
        wait_idle(200);
        chk("wait0_count", 32'(s_cyc.size() - base), 32'd2);
        if (s_cyc.size() == base + 2) begin
            chk_strobe("wait0_second", base + 1, 3'd0, 5'd2);
            chk("wait0_space", 32'(s_cyc[base+1] - s_cyc[base]), 32'd4);
        end
        chk("no_addr7_strobe", 32'(a7_cnt), 32'd0);

        // Reset while waiting with two commands queued.
        send(8'hE5);
        send(8'h23);
        send(8'h44);
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("wait_hold_data", 32'(data), 32'd2);
        chk("wait_busy",      32'(busy), 32'd1);
`else
        // Address 7 is an ordinary write without the wait feature.
        base = s_cyc.size();
        send(8'hE3);
        cmd_valid = 1'b0;
        wait_idle(200);
        chk("a7_count", 32'(s_cyc.size() - base), 32'd1);
        if (s_cyc.size() == base + 1) chk_strobe("a7_write", base, 3'd7, 5'd3);
        chk("a7_strobes", 32'(a7_cnt), 32'd1);

        // Reset during GAP with two commands queued.
        send(8'h3F);
        send(8'h23);
        send(8'h44);
        cmd_valid = 1'b0;
        tick();
        chk("gap_hold_data", 32'(data), 32'd31);
        chk("gap_busy",      32'(busy), 32'd1);
`endif
        rst = 1'b1;
        tick();
        chk("midrst_strobe", 32'(write_strobe), 32'd0);
        chk("midrst_addr",   32'(address),      32'd0);
        chk("midrst_data",   32'(data),         32'd0);
        chk("midrst_busy",   32'(busy),         32'd0);
        chk("midrst_ready",  32'(cmd_ready),    32'd1);
        rst  = 1'b0;
        base = s_cyc.size();
        repeat (40) tick();
        chk("midrst_no_strobe", 32'(s_cyc.size() - base), 32'd0);
        chk("midrst_idle",      32'(busy),                32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
